cov_3b4b_rx: RTL and testbench

COV_3B4B_RX -- requirements
Module: cov_3b4b_rx

---
 rtl/cov_3b4b_rx.sv | 111 +++++++++++
 tb/tb_cov_3b4b_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cov_3b4b_rx.sv
// cov_3b4b_rx: repacks 3-bit line symbols LSB-first into 4-bit MII nibbles.
// Define COV_3B4B_RX_FLUSH_ERR_EN to flush residual bits as a padded error nibble.
module cov_3b4b_rx #(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic       sys_clk_33m,
  input  logic       rst_n_33m,
  input  logic [2:0] rx_data,
  input  logic       rx_data_en,
  output logic [3:0] RXD,
  output logic       rxd_vld,
  output logic       rx_dv,
  output logic       rx_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t     r_state;
  logic [5:0] r_acc;
  logic [1:0] r_cnt;

  logic [5:0] w_merged;
  logic [2:0] w_sum;
  logic       w_emit;
  logic [5:0] w_acc_nx;

  assign w_merged = r_acc | ({3'b000, rx_data} << r_cnt);
  assign w_sum    = {1'b0, r_cnt} + 3'd3;
  assign w_emit   = w_sum[2];
  assign w_acc_nx = w_emit ? (w_merged >> 4) : w_merged;

`ifdef COV_3B4B_RX_FLUSH_ERR_EN
  logic [3:0] w_flush_nib;

  always_comb begin
    w_flush_nib = {4{PAD_BIT}};
    for (int i = 0; i < 3; i++) begin
      if (i < int'(r_cnt)) w_flush_nib[i] = r_acc[i];
    end
  end
`else
  logic w_unused_pad;
  assign w_unused_pad = PAD_BIT;
  assign rx_err       = 1'b0;
`endif

  // cnt+3 never exceeds 6, so sum[1:0] is the next fill in both cases
  always_ff @(posedge sys_clk_33m or negedge rst_n_33m) begin
    if (!rst_n_33m) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      RXD     <= '0;
      rxd_vld <= 1'b0;
      rx_dv   <= 1'b0;
`ifdef COV_3B4B_RX_FLUSH_ERR_EN
      rx_err  <= 1'b0;
`endif
    end else begin
      rxd_vld <= 1'b0;
`ifdef COV_3B4B_RX_FLUSH_ERR_EN
      rx_err  <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE, S_RUN: begin
          if (rx_data_en) begin
            r_state <= S_RUN;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_sum[1:0];
            if (w_emit) begin
              RXD     <= w_merged[3:0];
              rxd_vld <= 1'b1;
              rx_dv   <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            rx_dv   <= 1'b0;
`ifdef COV_3B4B_RX_FLUSH_ERR_EN
            if (r_state == S_RUN && r_cnt != 2'd0) begin
              r_state <= S_FLUSH;
              RXD     <= w_flush_nib;
              rxd_vld <= 1'b1;
              rx_err  <= 1'b1;
              rx_dv   <= 1'b1;
            end
`endif
          end
        end
        S_FLUSH: begin
          r_state <= S_IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
          rx_dv   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
          rx_dv   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cov_3b4b_rx.sv
// tb_cov_3b4b_rx: random and directed frames checked against
// a bit-queue repacking model of the 3b->4b receiver.
module tb_cov_3b4b_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] rx_data = 3'd0;
  logic       rx_data_en = 1'b0;
  logic [3:0] RXD;
  logic       rxd_vld;
  logic       rx_dv;
  logic       rx_err;

  always #5 clk = ~clk;

  cov_3b4b_rx #(.PAD_BIT(1'b0)) u_dut (
    .sys_clk_33m (clk),
    .rst_n_33m   (rst_n),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .RXD         (RXD),
    .rxd_vld     (rxd_vld),
    .rx_dv       (rx_dv),
    .rx_err      (rx_err)
  );

`ifdef COV_3B4B_RX_FLUSH_ERR_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  bit         mq[$];
  bit         m_in = 1'b0;
  bit         m_flush = 1'b0;
  logic       e_vld = 1'b0;
  logic       e_dv = 1'b0;
  logic       e_err = 1'b0;
  logic [3:0] e_rxd = 4'd0;
  logic [3:0] obs[$];
  int         run_len = 0;
  int         max_run = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic en, input logic [2:0] d);
    logic [3:0] n;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (m_flush) begin
      m_flush = 1'b0;
      m_in    = 1'b0;
      mq.delete();
      e_dv    = 1'b0;
    end else if (en) begin
      if (!m_in) begin
        m_in = 1'b1;
        mq.delete();
      end
      for (int i = 0; i < 3; i++) mq.push_back(d[i]);
      if (mq.size() >= 4) begin
        for (int i = 0; i < 4; i++) n[i] = mq.pop_front();
        e_vld = 1'b1;
        e_rxd = n;
        e_dv  = 1'b1;
      end
    end else begin
      if (FLUSH && m_in && mq.size() != 0) begin
        n = 4'b0000;
        for (int i = 0; i < 4; i++)
          if (mq.size() != 0) n[i] = mq.pop_front();
        e_vld   = 1'b1;
        e_err   = 1'b1;
        e_dv    = 1'b1;
        e_rxd   = n;
        m_flush = 1'b1;
      end else begin
        e_dv = 1'b0;
      end
      m_in = 1'b0;
      mq.delete();
    end
  endtask

  task automatic step(input logic en, input logic [2:0] d);
    rx_data_en = en;
    rx_data    = d;
    @(posedge clk);
    model(en, d);
    @(negedge clk);
    chk("vld", rxd_vld, e_vld);
    chk("dv", rx_dv, e_dv);
    chk("err", rx_err, e_err);
    chk("rxd", RXD, e_rxd);
    if (rxd_vld === 1'b1) begin
      obs.push_back(RXD);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic model_reset();
    m_in    = 1'b0;
    m_flush = 1'b0;
    mq.delete();
    e_vld   = 1'b0;
    e_dv    = 1'b0;
    e_err   = 1'b0;
    e_rxd   = 4'd0;
  endtask

  task automatic frame_5461();
    step(1'b1, 3'd5);
    step(1'b1, 3'd4);
    step(1'b1, 3'd6);
    step(1'b1, 3'd1);
  endtask

  initial begin
    bit         ref_bits[$];
    logic [2:0] sym;
    logic [3:0] en4;
    int         len;
    int         gap;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rxd", RXD, 4'd0);
    chk("rst_vld", rxd_vld, 1'b0);
    chk("rst_dv", rx_dv, 1'b0);
    chk("rst_err", rx_err, 1'b0);
    #2 rst_n = 1'b1;
    model_reset();
    step(1'b0, 3'd7);

    obs.delete();
    frame_5461();
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    chk("s4_cnt", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("s4_n0", obs[0], 4'h5);
      chk("s4_n1", obs[1], 4'hA);
      chk("s4_n2", obs[2], 4'h3);
    end

    obs.delete();
    frame_5461();
    step(1'b1, 3'd7);
    step(1'b0, 3'd0);
    chk("s5_dv_after_fall", rx_dv, FLUSH);
    chk("s5_err_after_fall", rx_err, FLUSH);
    step(1'b0, 3'd0);
    chk("s5_dv_drop", rx_dv, 1'b0);
    step(1'b0, 3'd0);
    chk("s5_cnt", obs.size(), FLUSH ? 4 : 3);
    if (obs.size() == 4) chk("s5_flush", obs[3], 4'h7);

    obs.delete();
    frame_5461();
    step(1'b0, 3'd0);
    chk("gap_dv_low", rx_dv, 1'b0);
    frame_5461();
    step(1'b0, 3'd0);
    chk("s2f_cnt", obs.size(), 6);
    if (obs.size() == 6) begin
      chk("s2f_n3", obs[3], 4'h5);
      chk("s2f_n4", obs[4], 4'hA);
      chk("s2f_n5", obs[5], 4'h3);
    end

    step(1'b1, 3'd5);
    step(1'b1, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rxd", RXD, 4'd0);
    chk("mrst_vld", rxd_vld, 1'b0);
    chk("mrst_dv", rx_dv, 1'b0);
    chk("mrst_err", rx_err, 1'b0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    chk("mrst_noflush", rxd_vld, 1'b0);
    obs.delete();
    frame_5461();
    step(1'b0, 3'd0);
    chk("mrst_cnt", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("mrst_n0", obs[0], 4'h5);
      chk("mrst_n1", obs[1], 4'hA);
      chk("mrst_n2", obs[2], 4'h3);
    end

    obs.delete();
    ref_bits.delete();
    max_run = 0;
    for (int k = 0; k < 400; k++) begin
      sym = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) ref_bits.push_back(sym[i]);
      step(1'b1, sym);
    end
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    chk("long_cnt", obs.size(), 300);
    chk("long_run_le3", (max_run <= 3), 1'b1);
    for (int k = 0; k < 300 && k < obs.size(); k++) begin
      for (int i = 0; i < 4; i++) en4[i] = ref_bits[4 * k + i];
      if (obs[k] !== en4) chk("long_nib", obs[k], en4);
    end

    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 13);
      gap = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) step(1'b1, 3'($urandom_range(0, 7)));
      for (int k = 0; k < gap; k++) step(1'b0, 3'($urandom_range(0, 7)));
    end
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
